// File: rtl/program_loader_if.sv
// Program memory port shared by the loader (master) and the memory (slave).
interface program_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    localparam int unsigned WORD_W = 4;

    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_data;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_data,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_data,
        input  mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/program_loader.sv
// Interactive program loader: button-driven entry of 4-bit opcodes into a
// program memory, with bracket-depth tracking, backspace and a terminating
// stop word. All outputs are registered.
module program_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              enter,
    input  logic              backspace,
    input  logic              finish,
    input  logic [3:0]        cmd_in,
    program_loader_if.master  mem,
    output logic [ADDR_W-1:0] prog_len,
    output logic [ADDR_W-1:0] depth,
    output logic              busy,
    output logic              ready,
    output logic              reject
);
    localparam int unsigned WORD_W = 4;

    localparam logic [WORD_W-1:0] OP_OPEN    = 4'd4;
    localparam logic [WORD_W-1:0] OP_CLOSE   = 4'd5;
    localparam logic [WORD_W-1:0] OP_BAD_LO  = 4'd8;
    localparam logic [WORD_W-1:0] OP_BAD_HI  = 4'd14;
    localparam logic [WORD_W-1:0] OP_STOP    = 4'd15;
    localparam logic [ADDR_W-1:0] WP_LAST    = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WRITE,
        BK_RD,
        BK_ADJ,
        TERM,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] dep;
    logic              enter_q;
    logic              backspace_q;
    logic              finish_q;

    logic              enter_edge;
    logic              backspace_edge;
    logic              finish_edge;
    logic              fin_req;
    logic              bk_req;
    logic              ent_req;
    logic              cmd_illegal;
    logic              enter_ok;

    assign prog_len = wp;
    assign depth    = dep;

    // Button edges and priority resolution (finish > backspace > enter).
    always_comb begin
        enter_edge     = enter & ~enter_q;
        backspace_edge = backspace & ~backspace_q;
        finish_edge    = finish & ~finish_q;
        // A stop opcode entered via enter behaves exactly like finish.
        fin_req        = finish_edge | (enter_edge & (cmd_in == OP_STOP));
        bk_req         = ~fin_req & backspace_edge;
        ent_req        = ~fin_req & ~backspace_edge & enter_edge;
        cmd_illegal    = (cmd_in >= OP_BAD_LO) && (cmd_in <= OP_BAD_HI);
        // Last slot is kept free for the stop word; ']' needs an open '['.
        enter_ok       = !cmd_illegal
                         && !((cmd_in == OP_CLOSE) && (dep == '0))
                         && (wp != WP_LAST);
    end

    // Loader FSM with registered memory port and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wp           <= '0;
            dep          <= '0;
            enter_q      <= 1'b0;
            backspace_q  <= 1'b0;
            finish_q     <= 1'b0;
            mem.mem_addr <= '0;
            mem.mem_data <= '0;
            mem.mem_we   <= 1'b0;
            busy         <= 1'b0;
            ready        <= 1'b0;
            reject       <= 1'b0;
        end else begin
            enter_q     <= enter;
            backspace_q <= backspace;
            finish_q    <= finish;
            reject      <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= ACCEPT;
                        wp           <= '0;
                        dep          <= '0;
                        mem.mem_addr <= '0;
                        busy         <= 1'b1;
                        ready        <= 1'b0;
                    end
                end

                ACCEPT: begin
                    if (fin_req) begin
                        if (dep != '0) begin
                            reject <= 1'b1;
                        end else begin
                            state        <= TERM;
                            mem.mem_we   <= 1'b1;
                            mem.mem_data <= OP_STOP;
                        end
                    end else if (bk_req) begin
                        if (wp == '0) begin
                            reject <= 1'b1;
                        end else begin
                            state        <= BK_RD;
                            mem.mem_addr <= wp - ONE;
                        end
                    end else if (ent_req) begin
                        if (!enter_ok) begin
                            reject <= 1'b1;
                        end else begin
                            state        <= WRITE;
                            mem.mem_we   <= 1'b1;
                            mem.mem_data <= cmd_in;
                        end
                    end
                end

                WRITE: begin
                    state        <= ACCEPT;
                    mem.mem_we   <= 1'b0;
                    mem.mem_data <= '0;
                    wp           <= wp + ONE;
                    mem.mem_addr <= wp + ONE;
                    if (mem.mem_data == OP_OPEN) begin
                        dep <= dep + ONE;
                    end else if (mem.mem_data == OP_CLOSE) begin
                        dep <= dep - ONE;
                    end
                end

                // Address wp-1 is already on the bus; wait out the read latency.
                BK_RD: begin
                    state <= BK_ADJ;
                end

                // Undo the depth effect of the removed command.
                BK_ADJ: begin
                    state <= ACCEPT;
                    wp    <= wp - ONE;
                    if (mem.mem_rdata == OP_OPEN) begin
                        dep <= dep - ONE;
                    end else if (mem.mem_rdata == OP_CLOSE) begin
                        dep <= dep + ONE;
                    end
                end

                TERM: begin
                    state        <= DONE;
                    mem.mem_we   <= 1'b0;
                    mem.mem_data <= '0;
                    busy         <= 1'b0;
                    ready        <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected memory
// writes and reject pulses; a monitor pops and compares them.
module tb_program_loader;
    localparam int unsigned AW = 3;

    typedef struct packed {
        logic          is_rej;
        logic [AW-1:0] addr;
        logic [3:0]    data;
    } ev_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic          enter;
    logic          backspace;
    logic          finish;
    logic [3:0]    cmd_in;
    logic [AW-1:0] prog_len;
    logic [AW-1:0] depth;
    logic          busy;
    logic          ready;
    logic          reject;

    logic [3:0]    mem_model [2**AW];
    ev_t           exp_q [$];
    int            checks;
    int            errors;

    program_loader_if #(.ADDR_W(AW)) mem_if ();

    program_loader #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .enter     (enter),
        .backspace (backspace),
        .finish    (finish),
        .cmd_in    (cmd_in),
        .mem       (mem_if),
        .prog_len  (prog_len),
        .depth     (depth),
        .busy      (busy),
        .ready     (ready),
        .reject    (reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory with one-cycle read latency.
    always_ff @(posedge clk) begin
        if (mem_if.mem_we) begin
            mem_model[mem_if.mem_addr] <= mem_if.mem_data;
        end
        mem_if.mem_rdata <= mem_model[mem_if.mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_wr(input int a, input int d);
        ev_t e;
        e.is_rej = 1'b0;
        e.addr   = AW'(a);
        e.data   = 4'(d);
        exp_q.push_back(e);
    endtask

    task automatic push_rej(input int a);
        ev_t e;
        e.is_rej = 1'b1;
        e.addr   = AW'(a);
        e.data   = 4'd0;
        exp_q.push_back(e);
    endtask

    task automatic press(input logic e, input logic b, input logic f, input int c);
        @(negedge clk);
        cmd_in    = 4'(c);
        enter     = e;
        backspace = b;
        finish    = f;
        cyc(2);
        enter     = 1'b0;
        backspace = 1'b0;
        finish    = 1'b0;
        cyc(3);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc(1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        start     = 1'b0;
        enter     = 1'b0;
        backspace = 1'b0;
        finish    = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(1);
    endtask

    // Monitor: every write strobe or reject pulse must match the next expected event.
    initial begin
        ev_t got;
        ev_t e;
        forever begin
            @(negedge clk);
            if (mem_if.mem_we || reject) begin
                got = {reject, mem_if.mem_addr, mem_if.mem_data};
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 32'(got), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("event", 32'(got), 32'(e));
                end
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        enter     = 1'b0;
        backspace = 1'b0;
        finish    = 1'b0;
        cmd_in    = 4'd0;
        cyc(3);

        // Reset state
        chk("rst_mem_we", 32'(mem_if.mem_we), 0);
        chk("rst_mem_addr", 32'(mem_if.mem_addr), 0);
        chk("rst_mem_data", 32'(mem_if.mem_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_reject", 32'(reject), 0);
        chk("rst_prog_len", 32'(prog_len), 0);
        chk("rst_depth", 32'(depth), 0);
        reset = 1'b0;
        cyc(1);

        // Basic load: + [ - ] then finish
        pulse_start();
        chk("load_busy", 32'(busy), 1);
        chk("load_ready", 32'(ready), 0);
        push_wr(0, 2); press(1, 0, 0, 2);
        push_wr(1, 4); press(1, 0, 0, 4);
        chk("load_depth_open", 32'(depth), 1);
        push_wr(2, 3); press(1, 0, 0, 3);
        push_wr(3, 5); press(1, 0, 0, 5);
        chk("load_depth_close", 32'(depth), 0);
        chk("load_addr_tracks_wp", 32'(mem_if.mem_addr), 4);
        push_wr(4, 15); press(0, 0, 1, 0);
        chk("load_prog_len", 32'(prog_len), 4);
        chk("load_depth_end", 32'(depth), 0);
        chk("load_ready_end", 32'(ready), 1);
        chk("load_busy_end", 32'(busy), 0);

        // Bracket errors and start ignored while loading
        do_reset();
        pulse_start();
        push_rej(0); press(1, 0, 0, 5);
        chk("br_len_after_rej", 32'(prog_len), 0);
        push_wr(0, 4); press(1, 0, 0, 4);
        push_rej(1); press(0, 0, 1, 0);
        chk("br_depth", 32'(depth), 1);
        chk("br_busy", 32'(busy), 1);
        chk("br_ready", 32'(ready), 0);
        pulse_start();
        chk("br_start_ignored", 32'(prog_len), 1);

        // Backspace adjusts length and depth from read-back opcode
        do_reset();
        pulse_start();
        push_wr(0, 4); press(1, 0, 0, 4);
        push_wr(1, 2); press(1, 0, 0, 2);
        press(0, 1, 0, 0);
        chk("bk1_len", 32'(prog_len), 1);
        chk("bk1_depth", 32'(depth), 1);
        chk("bk1_addr", 32'(mem_if.mem_addr), 1);
        press(0, 1, 0, 0);
        chk("bk2_len", 32'(prog_len), 0);
        chk("bk2_depth", 32'(depth), 0);
        push_rej(0); press(0, 1, 0, 0);
        chk("bk3_len", 32'(prog_len), 0);
        push_wr(0, 4); press(1, 0, 0, 4);
        push_wr(1, 5); press(1, 0, 0, 5);
        chk("bk_close_depth0", 32'(depth), 0);
        press(0, 1, 0, 0);
        chk("bk_close_len", 32'(prog_len), 1);
        chk("bk_close_depth", 32'(depth), 1);

        // Simultaneous enter and finish: only the stop word is written
        do_reset();
        pulse_start();
        push_wr(0, 15); press(1, 0, 1, 2);
        chk("sim_len", 32'(prog_len), 0);
        chk("sim_ready", 32'(ready), 1);

        // Illegal opcode rejected; enter with stop opcode terminates
        do_reset();
        pulse_start();
        push_wr(0, 2); press(1, 0, 0, 2);
        push_rej(1); press(1, 0, 0, 9);
        push_wr(1, 15); press(1, 0, 0, 15);
        chk("stop_len", 32'(prog_len), 1);
        chk("stop_ready", 32'(ready), 1);

        // Full memory: last slot reserved for the stop word
        do_reset();
        pulse_start();
        begin
            int cmds [7] = '{0, 1, 2, 3, 6, 7, 0};
            for (int i = 0; i < 7; i++) begin
                push_wr(i, cmds[i]);
                press(1, 0, 0, cmds[i]);
            end
        end
        chk("full_len7", 32'(prog_len), 7);
        push_rej(7); press(1, 0, 0, 1);
        chk("full_len_after_rej", 32'(prog_len), 7);
        push_wr(7, 15); press(0, 0, 1, 0);
        chk("full_ready", 32'(ready), 1);

        // Reset during WRITE aborts; held enter gives no new write
        do_reset();
        pulse_start();
        @(negedge clk);
        cmd_in = 4'd2;
        enter  = 1'b1;
        push_wr(0, 2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstw_mem_we", 32'(mem_if.mem_we), 0);
        chk("rstw_len", 32'(prog_len), 0);
        chk("rstw_busy", 32'(busy), 0);
        reset = 1'b0;
        cyc(2);
        pulse_start();
        cyc(6);
        chk("held_len", 32'(prog_len), 0);
        chk("held_busy", 32'(busy), 1);
        enter = 1'b0;
        cyc(3);

        chk("pending_events", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter: ADDR_W, default 8, program memory address width; depth = 2^ADDR_W words of 4 bits.
REQ-002 clk  in  1  clock; all state changes on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse; clears the program and begins a load session.
REQ-005 enter  in  1  level button; a rising edge commits cmd_in.
REQ-006 backspace  in  1  level button; a rising edge removes the last committed command.
REQ-007 finish  in  1  level button; a rising edge requests termination.
REQ-008 cmd_in  in  4  opcode: 0 '<', 1 '>', 2 '+', 3 '-', 4 '[', 5 ']', 6 '.', 7 ',', 15 stop.
REQ-009 mem_rdata  in  4  program memory read data; one-cycle read latency from mem_addr.
REQ-010 mem_addr  out  ADDR_W  program memory address.
REQ-011 mem_data  out  4  program memory write data.
REQ-012 mem_we  out  1  program memory write strobe.
REQ-013 prog_len  out  ADDR_W  number of committed commands, stop word excluded.
REQ-014 depth  out  ADDR_W  count of open '[' not yet matched.
REQ-015 busy  out  1  high in every state except IDLE and DONE.
REQ-016 ready  out  1  high only in DONE.
REQ-017 reject  out  1  one-cycle pulse when a request is refused.

Function
REQ-018 Edge detection: each button is registered once per cycle; edge = current high AND previous low.
REQ-019 Simultaneous edges: priority is finish > backspace > enter; lower-priority edges in the same cycle are discarded.
REQ-020 Edges arriving outside ACCEPT are discarded.
REQ-021 States: IDLE, ACCEPT, WRITE, BK_RD, BK_ADJ, TERM, DONE.
REQ-022 IDLE or DONE, start=1 -> ACCEPT; wp and depth are cleared to 0.
REQ-023 start is ignored in ACCEPT, WRITE, BK_RD, BK_ADJ and TERM.
REQ-024 ACCEPT, enter edge, accepted -> WRITE. In WRITE: mem_we=1, mem_addr=wp, mem_data=cmd_in latched at the edge; then wp+1 -> ACCEPT.
REQ-025 Write latency: mem_we asserts in the cycle after the detected edge, for exactly 1 cycle.
REQ-026 The enter request is rejected, with no write and the state staying ACCEPT, when any of these holds:
  - cmd_in is in 8..14;
  - cmd_in=5 and depth=0;
  - wp = 2^ADDR_W-1, because the last slot is reserved for stop.
REQ-027 depth update on write: cmd '[' -> depth+1; cmd ']' -> depth-1.
REQ-028 enter with cmd_in=15 is treated as a finish edge.
REQ-029 ACCEPT, backspace edge, wp=0 -> reject; the state stays ACCEPT.
REQ-030 ACCEPT, backspace edge, wp>0 -> BK_RD, with mem_addr=wp-1.
REQ-031 BK_ADJ uses mem_rdata: '[' -> depth-1; ']' -> depth+1; then wp-1 -> ACCEPT. No write is issued.
REQ-032 ACCEPT, finish edge, depth!=0 -> reject; the state stays ACCEPT.
REQ-033 ACCEPT, finish edge, depth=0 -> TERM. TERM writes mem_addr=wp, mem_data=15, mem_we=1 for 1 cycle -> DONE.
REQ-034 prog_len = wp at all times; wp never exceeds 2^ADDR_W-1.
REQ-035 mem_we is high only in WRITE and TERM.
REQ-036 mem_addr equals wp in every state except BK_RD and BK_ADJ, where it equals wp-1.
REQ-037 mem_data is 0 whenever mem_we=0.
REQ-038 The depth counter cannot underflow (REQ-026) and cannot overflow, because depth <= wp.

Reset
REQ-039 reset=1 -> IDLE; wp=0, depth=0, all edge registers=0.
REQ-040 Output values on reset: mem_we=0, mem_addr=0, mem_data=0, busy=0, ready=0, reject=0.
REQ-041 reset takes priority over start and over every button edge.
REQ-042 reset mid-WRITE or mid-TERM aborts the write in the following cycle; no further mem_we is issued.
REQ-043 Memory contents are not cleared by reset.

Verification
REQ-044 Load sequence: start, then enter cmd 2, 4, 3, 5, then finish -> writes at addresses 0..3 = 2,4,3,5 and address 4 = 15; prog_len=4, depth=0, ready=1.
REQ-045 Bracket errors:
  - enter cmd 5 at depth 0 -> reject pulse, no mem_we, prog_len unchanged;
  - enter 4, then finish -> reject, state stays ACCEPT, depth=1.
REQ-046 Backspace: enter 4, enter 2, backspace (mem_rdata=2) -> prog_len=1, depth=1; backspace again (mem_rdata=4) -> prog_len=0, depth=0; third backspace -> reject.
REQ-047 Simultaneous edges: enter and finish rise in the same cycle with depth=0 -> only the stop word is written at wp; the enter command is not written.
REQ-048 Full memory (ADDR_W=3): commit 7 commands, then an 8th enter -> reject; finish -> stop word written at address 7.
REQ-049 Reset mid-operation: reset asserted during WRITE -> next cycle IDLE, mem_we=0, prog_len=0; a held enter with no new edge produces no write.
